// File: rtl/pi_disp_ctrl.sv
// Display value owner: arbitrates between a local source and bytes assembled
// from a 4-bit strobe/ack link driven by a Raspberry Pi.
module pi_disp_ctrl #(
  parameter int unsigned HOLD_CYC = 1000,
  parameter int unsigned TMO_CYC  = 5000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pi_stb,
  input  logic [3:0] pi_nib,
  output logic       pi_ack,
  input  logic       loc_valid,
  input  logic [7:0] loc_data,
  output logic       loc_ready,
  output logic [7:0] disp_data,
  output logic       disp_src,
  output logic       err
);

  typedef enum logic [1:0] {WAIT_HI, ACK_HI, WAIT_LO, ACK_LO} link_e;
  typedef enum logic {OWN_LOCAL, OWN_PI} own_e;

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

  logic             stb_m_q, stb_s_q, stb_p_q;
  logic [3:0]       nib_m_q, nib_s_q;
  logic             stb_rise;

  link_e            link_q, link_d;
  logic             ack_q, ack_d;
  logic [3:0]       hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             byte_done_q, byte_done_d;
  logic             err_q, err_d;

  own_e             own_q, own_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [7:0]       disp_q, disp_d;
  logic             src_q, src_d;
  logic             ready;

  // Two-flop synchronisers; stb_p_q holds the previous synchronised strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_m_q <= 1'b0;
      stb_s_q <= 1'b0;
      stb_p_q <= 1'b0;
      nib_m_q <= 4'h0;
      nib_s_q <= 4'h0;
    end else begin
      stb_m_q <= pi_stb;
      stb_s_q <= stb_m_q;
      stb_p_q <= stb_s_q;
      nib_m_q <= pi_nib;
      nib_s_q <= nib_m_q;
    end
  end

  assign stb_rise = stb_s_q & ~stb_p_q;

  always_comb begin
    link_d      = link_q;
    ack_d       = ack_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    tmo_d       = tmo_q;
    byte_done_d = 1'b0;
    err_d       = 1'b0;
    case (link_q)
      WAIT_HI: begin
        if (stb_rise) begin
          hi_d   = nib_s_q;
          ack_d  = 1'b1;
          link_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!stb_s_q) begin
          ack_d  = 1'b0;
          tmo_d  = '0;
          link_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        tmo_d = tmo_q + 1'b1;
        // A strobe rise outranks a timeout landing in the same cycle
        if (stb_rise) begin
          lo_d        = nib_s_q;
          ack_d       = 1'b1;
          byte_done_d = 1'b1;
          link_d      = ACK_LO;
        end else if (tmo_q == TMO_LAST) begin
          err_d  = 1'b1;
          hi_d   = 4'h0;
          link_d = WAIT_HI;
        end
      end
      ACK_LO: begin
        if (!stb_s_q) begin
          ack_d  = 1'b0;
          link_d = WAIT_HI;
        end
      end
      default: link_d = WAIT_HI;
    endcase
  end

  assign ready = (own_q == OWN_LOCAL) && !byte_done_q;

  always_comb begin
    own_d  = own_q;
    hold_d = hold_q;
    disp_d = disp_q;
    src_d  = src_q;
    if (byte_done_q) begin
      disp_d = {hi_q, lo_q};
      src_d  = 1'b1;
      hold_d = HOLD_LOAD;
      own_d  = OWN_PI;
    end else if (own_q == OWN_PI) begin
      if (hold_q == '0) begin
        src_d = 1'b0;
        own_d = OWN_LOCAL;
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end else if (loc_valid && ready) begin
      disp_d = loc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_q      <= WAIT_HI;
      ack_q       <= 1'b0;
      tmo_q       <= '0;
      byte_done_q <= 1'b0;
      err_q       <= 1'b0;
      own_q       <= OWN_LOCAL;
      hold_q      <= '0;
      disp_q      <= 8'h00;
      src_q       <= 1'b0;
    end else begin
      link_q      <= link_d;
      ack_q       <= ack_d;
      tmo_q       <= tmo_d;
      byte_done_q <= byte_done_d;
      err_q       <= err_d;
      own_q       <= own_d;
      hold_q      <= hold_d;
      disp_q      <= disp_d;
      src_q       <= src_d;
    end
  end

  // Nibble holding registers are pure data and need no reset
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  assign pi_ack    = ack_q;
  assign loc_ready = ready;
  assign disp_data = disp_q;
  assign disp_src  = src_q;
  assign err       = err_q;

endmodule

// File: doc/pi_disp_ctrl.md
Name: pi_disp_ctrl

Overview:
- Owns the 8-bit display value that drives the seven-segment decoder and the LED bank.
- Shares that value between two requesters: the Raspberry Pi nibble link (4-bit data plus strobe/ack over GPIO) and a local on-board source (for example the free-running counter).
- Assembles Pi nibbles into bytes using a 4-phase handshake.
- Grants the Pi display ownership for a programmable hold time, then returns ownership to the local source.

Parameters:
- HOLD_CYC, 1000: cycles a Pi byte keeps display ownership after it is written.
- TMO_CYC, 5000: maximum cycles allowed between high-nibble and low-nibble capture before the partial byte is discarded.
- CNT_W, 16: width of the hold and timeout counters. HOLD_CYC and TMO_CYC must each be less than 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pi_stb  in  1  Pi strobe; asynchronous to clk.
- pi_nib  in  4  Pi nibble; asynchronous, stable while pi_stb is high.
- pi_ack  out  1  handshake acknowledge to Pi.
- loc_valid  in  1  local source has data.
- loc_data  in  8  local display value.
- loc_ready  out  1  local value accepted this cycle when loc_valid is also high.
- disp_data  out  8  value fed to the seg decoder and LEDs.
- disp_src  out  1  current owner: 0 = local, 1 = Pi.
- err  out  1  one-cycle pulse on nibble timeout.

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears:
  - Outputs: disp_data=8'h00, disp_src=0, pi_ack=0, err=0.
  - Internal state: owner=LOCAL, link FSM=WAIT_HI, hold and timeout counters=0, synchroniser flops=0, byte_done=0.
  - Reset mid-handshake leaves pi_ack low; the Pi must restart from the high nibble.
- Synchroniser: pi_stb and pi_nib each pass through two flops, giving stb_s and nib_s. A rise is detected as stb_s=1 and prior stb_s=0.
- Link FSM, with pi_ack registered:
  - WAIT_HI: on a rise, capture nib_s into hi[3:0], set pi_ack=1, go to ACK_HI.
  - ACK_HI: when stb_s=0, set pi_ack=0, clear the timeout counter, go to WAIT_LO.
  - WAIT_LO: the timeout counter increments every cycle.
    - On a rise: capture nib_s as lo, set pi_ack=1, pulse byte_done for 1 cycle, go to ACK_LO.
    - Else, if the counter reaches TMO_CYC-1: pulse err for 1 cycle, discard hi, go to WAIT_HI.
    - If a rise and the timeout occur in the same cycle, the rise wins.
  - ACK_LO: when stb_s=0, set pi_ack=0, go to WAIT_HI.
  - Latency: a pin-level stb rise before edge N is captured, and pi_ack goes high, at edge N+2.
- Ownership FSM:
  - LOCAL:
    - loc_ready = (owner==LOCAL) && !byte_done. It is derived from registers only.
    - When loc_valid && loc_ready: disp_data <= loc_data at the same edge, so the new value is visible the next cycle.
    - When byte_done: disp_data <= {hi,lo}, disp_src <= 1, hold counter <= HOLD_CYC-1, go to PI_HOLD.
    - When byte_done coincides with loc_valid, the Pi wins. loc_ready is 0 that cycle, so no local transfer occurs.
  - PI_HOLD:
    - loc_ready=0.
    - The hold counter decrements each cycle.
    - A new byte_done reloads the counter to HOLD_CYC-1 and updates disp_data.
    - When the counter is 0 and there is no byte_done: disp_src <= 0, owner <= LOCAL. disp_data keeps the Pi value until the next local transfer.
- Latency from low-nibble capture (edge M, byte_done high after M) to disp_data/disp_src update: edge M+1.
- The Pi must hold pi_nib stable from before the stb rise until pi_ack is seen high. Glitches shorter than one cycle are not guaranteed to be seen.

Test Plan:
1. Reset, then hold loc_valid=1 with loc_data=8'h3C -> loc_ready=1; disp_data=8'h3C one cycle later; disp_src=0.
2. Pi sends nibbles 4'hA then 4'h5 with full handshakes -> pi_ack rises 2 cycles after each stb rise and falls after stb falls. disp_data=8'hA5 and disp_src=1 one cycle after the low-nibble capture. loc_ready=0 for HOLD_CYC cycles, then disp_src=0 and loc_ready=1, with disp_data still 8'hA5.
3. HOLD_CYC=8: send a second byte 8'h12 during hold, 4 cycles before expiry -> disp_data=8'h12; hold restarts for a full 8 cycles.
4. Send the high nibble 4'h7, then no strobe for TMO_CYC cycles -> err pulses exactly 1 cycle and FSM returns to WAIT_HI. Next nibbles 4'h1 and 4'h2 give disp_data=8'h12, not 8'h71.
5. Local loc_valid=1 (loc_data=8'hFF) held in the cycle byte_done is high for 8'h5A -> loc_ready=0 that cycle; disp_data=8'h5A; the local value is not shown until hold expiry.
6. Assert rst while in ACK_LO with pi_ack=1 -> next cycle pi_ack=0, disp_data=8'h00, disp_src=0, loc_ready=1.
